// File: rtl/cla_slice_subtractor_if.sv
// Handshake/bus bundle for cla_slice_subtractor.
//   start/a/b/bin : request side, driven by the master (sequential control)
//   busy/done     : status, driven by the subtractor
//   diff/bout/ovf : result, valid on the done pulse and held until the next completion
interface cla_slice_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/cla_slice_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin.
// One 4-bit slice per clock, LSB slice first, through a borrow-lookahead stage.
// The slice borrow is registered between cycles.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset, has priority over start
//   bus : slave side of cla_slice_subtractor_if
//         (start/a/b/bin in; busy/done/diff/bout/ovf out)

// 4-bit borrow-lookahead slice. Each borrow is a flat sum of products,
// so there is no ripple path through the slice.
module cla_slice_bla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = ~a & b;      // this bit generates a borrow
  assign p = ~(a ^ b);    // equal bits pass an incoming borrow through

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign d    = a ^ b ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_slice_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  cla_slice_subtractor_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] wa, wb, wd;     // latched operands and partial result
  logic             brw;            // borrow carried into the current slice
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q, done_q;

  logic [3:0]       sa, sb, sd;
  logic             sbo;
  logic [WIDTH-1:0] res;            // working result with the current slice merged in
  logic             last;

  // Current slice operands.
  always_comb begin
    sa = wa[4*k +: 4];
    sb = wb[4*k +: 4];
  end

  cla_slice_bla4 u_bla (
    .a    (sa),
    .b    (sb),
    .cin  (brw),
    .d    (sd),
    .cout (sbo)
  );

  always_comb begin
    res = wd;
    res[4*k +: 4] = sd;
  end

  assign last = (state == RUN) && (k == KLAST);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (k == KLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath; result registers only move on completion or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      wa     <= '0;
      wb     <= '0;
      wd     <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          wa  <= bus.a;
          wb  <= bus.b;
          wd  <= '0;
          brw <= bus.bin;
          k   <= '0;
        end
      end else begin
        wd  <= res;
        brw <= sbo;
        k   <= k + 1'b1;
        if (last) begin
          diff_q <= res;
          bout_q <= sbo;
          // Operand signs differ and the result sign departs from the minuend.
          ovf_q  <= (wa[WIDTH-1] != wb[WIDTH-1]) & (res[WIDTH-1] != wa[WIDTH-1]);
          done_q <= 1'b1;
          k      <= '0;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cla_slice_subtractor.sv
module tb_cla_slice_subtractor;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  cla_slice_subtractor_if #(.WIDTH(WIDTH)) bus ();

  cla_slice_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; stimulus and sampling both happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done, returning how many edges it took (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                    input logic [15:0] ed, input logic eb, input logic eo);
    int n;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    step();
    chk({tag, "_busy"}, bus.busy, 1);
    bus.start = 1'b0;
    wait_done(n);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_diff"}, bus.diff, ed);
    chk({tag, "_bout"}, bus.bout, eb);
    chk({tag, "_ovf"}, bus.ovf, eo);
    step();
    chk({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    int n, m, seen;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    chk("rst_ovf",  bus.ovf,  0);

    op("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    op("uflow",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    op("ovfneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    op("ovfpos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    op("binprop",16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    op("binmix", 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0);
    op("mixed",  16'hA5C3, 16'h3C5A, 1'b0, 16'h6969, 1'b0, 1'b1);

    // start held through busy, operands changed mid-run
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0234; bus.bin = 1'b0;
    step();
    bus.a = 16'hFFFF; bus.b = 16'h1111; bus.bin = 1'b1;
    wait_done(n);
    chk("hold_lat", n, 4);
    chk("hold_diff", bus.diff, 16'h1000);
    // back-to-back start in the done cycle
    bus.a = 16'h00FF; bus.b = 16'h000F; bus.bin = 1'b0;
    step();
    m = 1;
    chk("b2b_done_drop", bus.done, 0);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_diff_held", bus.diff, 16'h1000);
    bus.start = 1'b0;
    wait_done(n);
    chk("b2b_gap", m + n, 5);
    chk("b2b_diff", bus.diff, 16'h00F0);
    step();

    // reset mid-run
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0234;
    step();
    bus.start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_diff", bus.diff, 0);
    chk("mrst_bout", bus.bout, 0);
    chk("mrst_ovf",  bus.ovf,  0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) seen++;
    end
    chk("mrst_nodone", seen, 0);
    op("after_rst", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_slice_subtractor.md
Name: cla_slice_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing diff = a - b - bin.
- Processes one 4-bit slice per clock, LSB slice first, through a 4-bit borrow-lookahead stage; the slice borrow is registered between cycles.
- Subtraction counterpart of the team's 4-bit carry-lookahead adder, with a start/busy/done handshake for use by sequential datapath control.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NSLICE = WIDTH/4 is derived internally and is not overridable.

Ports:
- clk    input   1      single clock; all state updates on the rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only while busy=0
- a      input   WIDTH  minuend; sampled on the accepted start edge
- b      input   WIDTH  subtrahend; sampled on the accepted start edge
- bin    input   1      borrow-in; sampled on the accepted start edge
- busy   output  1      high while slices are being computed
- done   output  1      one-cycle pulse; diff, bout and ovf are valid
- diff   output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout   output  1      final borrow-out; 1 when unsigned a < b + bin
- ovf    output  1      two's-complement overflow of the subtraction

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (rst).
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, slice counter=0, working regs=0. rst has priority over start.
- Reset mid-operation: abort immediately, no done pulse, outputs read 0 on the next cycle.
- States: IDLE and RUN.
- IDLE:
  - start=1 at an edge -> latch a, b and bin into working regs; slice counter k=0; borrow reg=bin; go to RUN; busy=1 from the next cycle.
  - done deasserts on this same edge.
- RUN, slice k (bits 4k+3..4k):
  - Per bit: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); d_i = a_i ^ b_i ^ c_i.
  - c_0 = registered borrow.
  - Borrows in lookahead form: c_{i+1} = g_i | p_i&g_{i-1} | ... | p_i..p_0&c_0; no ripple chain.
  - The slice result goes into working diff bits 4k+3..4k; the slice borrow-out goes into the borrow reg; k increments.
- Last slice (k = NSLICE-1), on that edge:
  - diff <= full working result; bout <= final borrow.
  - ovf <= (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]), using the latched operands.
  - busy <= 0; done <= 1; state returns to IDLE.
- Latency:
  - Start accepted at edge E0 -> busy=1 during cycles E0..E(NSLICE-1).
  - done=1 for exactly one cycle after edge E(NSLICE); WIDTH=16 gives 4 cycles.
- diff, bout and ovf change only at completion or reset. They hold the last result until the next completion; they are not cleared by start.
- start while busy=1 is ignored. The operands are not re-sampled and the operation is not restarted.
- Back-to-back operation: start=1 in the done cycle (busy=0) is accepted. done then drops and busy rises after that edge, giving 1 start per NSLICE+1 cycles.
- bin applies only to slice 0. Borrows never wrap from the MSB to the LSB.
- Inputs a, b and bin may change freely while busy=1 without affecting the result.

Test Plan:
- WIDTH=16:
  - a=0x1234, b=0x0234, bin=0 -> done exactly 4 cycles after start; diff=0x1000, bout=0, ovf=0, busy high for 4 cycles.
  - a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0 (borrow propagates through all 4 slices).
  - a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
  - a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0 (full propagate chain fed by bin).
- Handshake: start held high through busy with operands changed mid-run -> first result (0x1234-0x0234=0x1000) unaffected. A start re-sampled in the done cycle with a=0x00FF, b=0x000F gives a second done 5 cycles after the first, diff=0x00F0.
- Reset: rst=1 two cycles into a run -> the next cycle shows busy=0, done=0, diff=0, bout=0, ovf=0, with no done pulse afterwards. A new start after rst releases completes normally.
